gold_nic: RTL and testbench
===========================

GOLD_NIC -- requirements
Module: gold_nic

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have: reset  input  1  asynchronous active-low reset.
REQ-003 SHALL have: addr  input  2  processor register select: 00 in-data, 01 in-status, 10 out-data, 11 out-status.
REQ-004 SHALL have: d_in  input  64  processor write data.
REQ-005 SHALL have: d_out  output  64  processor read data.
REQ-006 SHALL have: nicEn  input  1  processor access enable.
REQ-007 SHALL have: nicWrEn  input  1  1 = write, 0 = read; qualified by nicEn.
REQ-008 SHALL have: net_si  output  1  send request to router PE input port.
REQ-009 SHALL have: net_ri  input  1  router PE input port ready.
REQ-010 SHALL have: net_di  output  64  packet to router.
REQ-011 SHALL have: net_so  input  1  router PE output port packet valid.
REQ-012 SHALL have: net_ro  output  1  NIC ready to accept a packet from router.
REQ-013 SHALL have: net_do  input  64  packet from router.
REQ-014 SHALL have: net_polarity  input  1  ring polarity; toggles every cycle.

Function
REQ-015 SHALL hold one 64-bit output buffer (obuf) with full flag ofull, and one 64-bit input buffer (ibuf) with full flag ifull.
REQ-016 SHALL treat obuf[63] as the packet VC bit; no other packet field is interpreted.
REQ-017 Processor write (nicEn=1, nicWrEn=1, addr=10) with ofull=0 SHALL load obuf<=d_in and set ofull at the edge.
REQ-018 Processor write to addr=10 with ofull=1 SHALL be ignored (obuf unchanged), even if a send completes in the same cycle.
REQ-019 Processor writes to addr 00, 01, 11 SHALL be ignored.
REQ-020 net_si SHALL be combinational: ofull & net_ri & (obuf[63]==net_polarity); net_di SHALL equal obuf at all times.
REQ-021 At an edge where net_si=1, ofull SHALL clear; a packet is sent exactly once.
REQ-022 If polarity mismatches, net_si SHALL stay 0 and obuf SHALL be held until the matching-polarity cycle with net_ri=1 (worst-case wait 1 cycle with net_ri held high).
REQ-023 net_ro SHALL equal ~ifull combinationally.
REQ-024 At an edge with net_so=1 and ifull=0, ibuf<=net_do and ifull SHALL set.
REQ-025 net_so=1 while ifull=1 SHALL be ignored (ibuf and ifull unchanged).
REQ-026 Processor read (nicEn=1, nicWrEn=0) SHALL drive d_out combinationally: addr 00 -> ibuf; 01 -> {63'b0, ifull}; 10 -> obuf; 11 -> {63'b0, ofull}.
REQ-027 Read of addr 00 with ifull=1 SHALL clear ifull at that edge; ibuf value retained until next arrival.
REQ-028 Read of addr 00 with ifull=0 SHALL return ibuf and leave state unchanged.
REQ-029 d_out SHALL be 64'b0 whenever nicEn=0 or nicWrEn=1.
REQ-030 Receive-path and send-path updates in the same cycle SHALL be independent and both take effect.
REQ-031 A packet arriving at the edge that clears ifull SHALL NOT be accepted (net_ro was 0); acceptance is possible from the next cycle.

Reset
REQ-032 reset=0 SHALL immediately, without a clock, clear ofull, ifull, obuf, ibuf; hence net_si=0, net_ro=1, net_di=0, d_out=0.
REQ-033 Reset asserted mid-operation SHALL discard any buffered packet; no send occurs until a new processor write after reset releases.

Verification
REQ-034 Reset: reset=0 with net_ri=1 -> net_si=0, net_ro=1, status reads 01/11 return 0 after release.
REQ-035 Send: write 64'h8000_0000_0000_00A5 to addr 10, net_ri=1 -> net_si=1 only in a cycle with net_polarity=1, net_di=8000_0000_0000_00A5, status 11 reads 0 the next cycle.
REQ-036 Backpressure: obuf full, net_ri=0 for 5 cycles -> net_si=0, obuf held; second write 64'h1 ignored; after net_ri=1 the original packet is sent once.
REQ-037 Receive: net_so=1, net_do=64'hDEAD_BEEF_0000_0001 -> net_ro=0 next cycle, read 00 returns DEAD_BEEF_0000_0001, net_ro=1 after the read edge.
REQ-038 Overrun: ibuf full, net_so=1 with net_do=64'h2 -> ibuf unchanged, ifull stays 1.
REQ-039 Concurrent: send completing and packet arriving in the same cycle -> ofull=0 and ifull=1 after the edge, both data values correct.

Source files
------------

// File: rtl/gold_nic.sv
// Single-slot network interface: one outbound buffer and one inbound buffer
// between a processor register port and a router PE port.
module gold_nic (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic [63:0] d_in,
  output logic [63:0] d_out,
  input  logic        nicEn,
  input  logic        nicWrEn,
  output logic        net_si,
  input  logic        net_ri,
  output logic [63:0] net_di,
  input  logic        net_so,
  output logic        net_ro,
  input  logic [63:0] net_do,
  input  logic        net_polarity
);

  localparam logic [1:0] ADDR_IN_DATA    = 2'b00;
  localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
  localparam logic [1:0] ADDR_OUT_DATA   = 2'b10;
  localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

  logic [63:0] r_obuf;
  logic        r_ofull;
  logic [63:0] r_ibuf;
  logic        r_ifull;

  logic w_send;
  logic w_wrObuf;
  logic w_rdIbuf;
  logic w_accept;
  logic w_procRead;

  // A packet may only leave on the ring phase matching its VC bit.
  assign w_send     = r_ofull & net_ri & (r_obuf[63] == net_polarity);
  assign w_procRead = nicEn & ~nicWrEn;
  assign w_wrObuf   = nicEn & nicWrEn & (addr == ADDR_OUT_DATA) & ~r_ofull;
  assign w_rdIbuf   = w_procRead & (addr == ADDR_IN_DATA) & r_ifull;
  assign w_accept   = net_so & ~r_ifull;

  assign net_si = w_send;
  assign net_di = r_obuf;
  assign net_ro = ~r_ifull;

  // A write is judged against the pre-edge full flag, so it never lands on a
  // slot that is only being freed by a send in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_obuf  <= '0;
      r_ofull <= 1'b0;
    end else if (w_wrObuf) begin
      r_obuf  <= d_in;
      r_ofull <= 1'b1;
    end else if (w_send) begin
      r_ofull <= 1'b0;
    end
  end

  // Accept and read-clear are mutually exclusive since they need opposite ifull.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ibuf  <= '0;
      r_ifull <= 1'b0;
    end else if (w_accept) begin
      r_ibuf  <= net_do;
      r_ifull <= 1'b1;
    end else if (w_rdIbuf) begin
      r_ifull <= 1'b0;
    end
  end

  always_comb begin
    d_out = '0;
    if (w_procRead) begin
      unique case (addr)
        ADDR_IN_DATA:    d_out = r_ibuf;
        ADDR_IN_STATUS:  d_out = {63'b0, r_ifull};
        ADDR_OUT_DATA:   d_out = r_obuf;
        ADDR_OUT_STATUS: d_out = {63'b0, r_ofull};
        default:         d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gold_nic.sv
// Randomised and directed bench for gold_nic, checked each cycle against a
// behavioural model of the two single-slot buffers.
module tb_gold_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_polarity;

  int total = 0;
  int bad   = 0;

  logic [63:0] mObuf;
  logic [63:0] mIbuf;
  bit          mOfull;
  bit          mIfull;
  logic [63:0] sentLog[$];
  logic [63:0] expSentLog[$];

  gold_nic dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelClear();
    mObuf  = '0;
    mIbuf  = '0;
    mOfull = 0;
    mIfull = 0;
  endtask

  task automatic checkAll(input string where);
    logic        expSi;
    logic [63:0] expDout;
    expSi   = mOfull && net_ri && (mObuf[63] == net_polarity);
    expDout = '0;
    if (nicEn && !nicWrEn) begin
      case (addr)
        2'b00: expDout = mIbuf;
        2'b01: expDout = {63'b0, mIfull};
        2'b10: expDout = mObuf;
        default: expDout = {63'b0, mOfull};
      endcase
    end
    checkOutput({where, ".net_si"}, {63'b0, net_si}, {63'b0, expSi});
    checkOutput({where, ".net_di"}, net_di, mObuf);
    checkOutput({where, ".net_ro"}, {63'b0, net_ro}, {63'b0, !mIfull});
    checkOutput({where, ".d_out"}, d_out, expDout);
    if (net_si === 1'b1) sentLog.push_back(net_di);
  endtask

  task automatic modelEdge();
    bit sendNow;
    bit wrOk;
    bit rdClr;
    bit acc;
    sendNow = mOfull && net_ri && (mObuf[63] == net_polarity);
    wrOk    = nicEn && nicWrEn && (addr == 2'b10) && !mOfull;
    rdClr   = nicEn && !nicWrEn && (addr == 2'b00) && mIfull;
    acc     = net_so && !mIfull;
    if (sendNow) begin
      mOfull = 0;
      expSentLog.push_back(mObuf);
    end
    if (wrOk) begin
      mObuf  = d_in;
      mOfull = 1;
    end
    if (rdClr) mIfull = 0;
    if (acc) begin
      mIbuf  = net_do;
      mIfull = 1;
    end
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model, cross the edge.
  task automatic applyStimulus(input string tag, input logic en, input logic wr,
                               input logic [1:0] a, input logic [63:0] din,
                               input logic ri, input logic so, input logic [63:0] ndo);
    nicEn        = en;
    nicWrEn      = wr;
    addr         = a;
    d_in         = din;
    net_ri       = ri;
    net_so       = so;
    net_do       = ndo;
    net_polarity = ~net_polarity;
    #3;
    checkAll(tag);
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input string tag);
    reset = 1'b0;
    #1;
    modelClear();
    checkAll(tag);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic idle(input string tag, input int n, input logic ri);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b1, 1'b0, 2'b11, 64'h0, ri, 1'b0, 64'h0);
  endtask

  initial begin
    reset        = 1'b1;
    nicEn        = 1'b0;
    nicWrEn      = 1'b0;
    addr         = 2'b00;
    d_in         = '0;
    net_ri       = 1'b1;
    net_so       = 1'b0;
    net_do       = '0;
    net_polarity = 1'b0;
    modelClear();
    @(posedge clk);
    #1;

    applyReset("reset");
    applyStimulus("rstIfull", 1'b1, 1'b0, 2'b01, 64'h0, 1'b1, 1'b0, 64'h0);
    applyStimulus("rstOfull", 1'b1, 1'b0, 2'b11, 64'h0, 1'b1, 1'b0, 64'h0);

    applyStimulus("sendWr", 1'b1, 1'b1, 2'b10, 64'h8000_0000_0000_00A5, 1'b1, 1'b0, 64'h0);
    idle("sendWait", 3, 1'b1);

    applyStimulus("bpWr", 1'b1, 1'b1, 2'b10, 64'h8000_0000_0000_00B6, 1'b0, 1'b0, 64'h0);
    idle("bpHold", 5, 1'b0);
    applyStimulus("bpWr2", 1'b1, 1'b1, 2'b10, 64'h1, 1'b0, 1'b0, 64'h0);
    applyStimulus("bpObuf", 1'b1, 1'b0, 2'b10, 64'h0, 1'b0, 1'b0, 64'h0);
    idle("bpRelease", 3, 1'b1);

    applyStimulus("rxArrive", 1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001);
    applyStimulus("rxOverrun", 1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b1, 64'h2);
    applyStimulus("rxStatus", 1'b1, 1'b0, 2'b01, 64'h0, 1'b0, 1'b1, 64'h2);
    applyStimulus("rxRead", 1'b1, 1'b0, 2'b00, 64'h0, 1'b0, 1'b1, 64'h3);
    applyStimulus("rxAfter", 1'b1, 1'b0, 2'b00, 64'h0, 1'b0, 1'b0, 64'h0);
    applyStimulus("rxEmptyRd", 1'b1, 1'b0, 2'b00, 64'h0, 1'b0, 1'b0, 64'h0);

    applyStimulus("ccWr", 1'b1, 1'b1, 2'b10, 64'h0000_0000_1234_5678, 1'b0, 1'b0, 64'h0);
    applyStimulus("ccBoth", 1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 1'b1, 64'hCAFE_0000_0000_0042);
    applyStimulus("ccBoth2", 1'b1, 1'b0, 2'b11, 64'h0, 1'b1, 1'b0, 64'h0);
    applyStimulus("ccIn", 1'b1, 1'b0, 2'b01, 64'h0, 1'b1, 1'b0, 64'h0);
    applyStimulus("ccRd", 1'b1, 1'b0, 2'b00, 64'h0, 1'b1, 1'b0, 64'h0);

    applyStimulus("ignWr0", 1'b1, 1'b1, 2'b00, 64'h55, 1'b0, 1'b0, 64'h0);
    applyStimulus("ignWr1", 1'b1, 1'b1, 2'b01, 64'h55, 1'b0, 1'b0, 64'h0);
    applyStimulus("ignWr3", 1'b1, 1'b1, 2'b11, 64'h55, 1'b0, 1'b0, 64'h0);

    applyStimulus("midWr", 1'b1, 1'b1, 2'b10, 64'h8000_0000_0000_0077, 1'b0, 1'b1, 64'h99);
    applyReset("midReset");
    idle("postReset", 3, 1'b1);

    for (int i = 0; i < 600; i++) begin
      if (i % 200 == 150) applyReset("rndReset");
      applyStimulus("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom),
                    2'($urandom), {$urandom, $urandom},
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                    {$urandom, $urandom});
    end

    checkOutput("sendCount", 64'(sentLog.size()), 64'(expSentLog.size()));
    for (int i = 0; i < sentLog.size() && i < expSentLog.size(); i++)
      checkOutput("sentPkt", sentLog[i], expSentLog[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
